// File: rtl/topk_pkg.sv
// Shared types and helpers for the streaming top-K tracker.
package topk_pkg;

  // Widest sample the comparator handles; samples are extended to this width.
  localparam int MAX_W = 64;

  // Per-edge operation broadcast from the top level to every slot.
  typedef enum logic [2:0] {
    OP_HOLD       = 3'd0,
    OP_CLEAR      = 3'd1,
    OP_INSERT     = 3'd2,
    OP_POP        = 3'd3,
    OP_POP_INSERT = 3'd4
  } slot_op_e;

  // Width of the occupancy counter (0..k inclusive).
  function automatic int cnt_w(input int k);
    return $clog2(k + 1);
  endfunction

  // Width of the rank selector (0..k-1).
  function automatic int rank_w(input int k);
    return (k < 2) ? 1 : $clog2(k);
  endfunction

  // Strict greater-than on pre-extended operands.
  function automatic logic gt(input logic [MAX_W-1:0] a,
                              input logic [MAX_W-1:0] b,
                              input logic             signed_mode);
    if (signed_mode) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

endpackage

// File: rtl/topk_slot.sv
// One rank of the sorted list. It reports whether its occupied value is
// >= din and picks its next value from its own and its neighbours' flags.
module topk_slot
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIGNED     = 0,
  parameter bit FIRST      = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  slot_op_e              op,
  input  logic                  occupied,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] prev_val,
  input  logic [DATA_WIDTH-1:0] next_val,
  input  logic                  ge_prev,
  input  logic                  ge_next,
  output logic                  ge_self,
  output logic [DATA_WIDTH-1:0] entry
);

  logic [DATA_WIDTH-1:0] entry_q, entry_d;

  // Extend a sample to comparator width according to the compare mode.
  function automatic logic [MAX_W-1:0] widen(input logic [DATA_WIDTH-1:0] v);
    if (SIGNED != 0) return MAX_W'($signed(v));
    else             return MAX_W'(v);
  endfunction

  // Empty slots never count as >= din, so they cannot hold back an insert.
  always_comb begin
    ge_self = occupied && !gt(widen(din), widen(entry_q), SIGNED != 0);
  end

  // Next value: keep, take din, or shift from the neighbour above/below.
  always_comb begin
    entry_d = entry_q;
    case (op)
      OP_CLEAR: entry_d = '0;
      OP_INSERT: begin
        // Slots ranked >= din keep; the first slot below them takes din;
        // the rest shift down one place.
        if (ge_self)              entry_d = entry_q;
        else if (FIRST || ge_prev) entry_d = din;
        else                      entry_d = prev_val;
      end
      OP_POP: entry_d = next_val;
      OP_POP_INSERT: begin
        // Equivalent to shifting up and then inserting into the shifted list.
        if (ge_next)              entry_d = next_val;
        else if (FIRST || ge_self) entry_d = din;
        else                      entry_d = entry_q;
      end
      default: entry_d = entry_q;
    endcase
  end

  // Entry register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) entry_q <= '0;
    else         entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/topk_tracker.sv
// Streaming top-K tracker: keeps the K largest samples (duplicates kept)
// sorted descending, with insert, pop-max, clear and combinational readout.
module topk_tracker
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  input  logic [rank_w(K)-1:0]  rank_sel,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] max_out,
  output logic [cnt_w(K)-1:0]   count
);

  localparam int CW = cnt_w(K);
  localparam int RW = rank_w(K);
  localparam logic [CW-1:0] K_CNT = CW'(K);

  logic [CW-1:0]         count_q, count_d;
  slot_op_e              op;
  logic [K-1:0]          occupied;
  logic [K-1:0]          ge;
  logic [DATA_WIDTH-1:0] entry [K];

  // Slot i holds a live sample when i < count.
  always_comb begin
    for (int i = 0; i < K; i++) occupied[i] = (count_q > CW'(i));
  end

  // Decode the edge's operation and the next count; clear wins over all.
  always_comb begin
    op      = OP_HOLD;
    count_d = count_q;
    if (clear) begin
      op      = OP_CLEAR;
      count_d = '0;
    end else if (pop && din_valid && (count_q != '0)) begin
      op = OP_POP_INSERT;
    end else if (din_valid) begin
      // When full and the last entry is >= din, din would land past the end.
      if (!ge[K-1]) begin
        op = OP_INSERT;
        if (count_q != K_CNT) count_d = count_q + 1'b1;
      end
    end else if (pop && (count_q != '0)) begin
      op      = OP_POP;
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  for (genvar i = 0; i < K; i++) begin : g_slot
    logic [DATA_WIDTH-1:0] prev_val;
    logic [DATA_WIDTH-1:0] next_val;
    logic                  ge_prev;
    logic                  ge_next;

    if (i == 0) begin : g_top
      assign prev_val = '0;
      assign ge_prev  = 1'b0;
    end else begin : g_mid_top
      assign prev_val = entry[i-1];
      assign ge_prev  = ge[i-1];
    end

    if (i == K - 1) begin : g_bot
      assign next_val = '0;
      assign ge_next  = 1'b0;
    end else begin : g_mid_bot
      assign next_val = entry[i+1];
      assign ge_next  = ge[i+1];
    end

    topk_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .SIGNED     (SIGNED),
      .FIRST      (i == 0)
    ) u_slot (
      .clk      (clk),
      .resetn   (resetn),
      .op       (op),
      .occupied (occupied[i]),
      .din      (din),
      .prev_val (prev_val),
      .next_val (next_val),
      .ge_prev  (ge_prev),
      .ge_next  (ge_next),
      .ge_self  (ge[i]),
      .entry    (entry[i])
    );
  end

  // Combinational rank readout; empty slots already hold 0.
  always_comb begin
    dout = '0;
    for (int i = 0; i < K; i++) begin
      if (rank_sel == RW'(i)) dout = entry[i];
    end
    dout_valid = (CW'(rank_sel) < count_q);
  end

  assign max_out = entry[0];
  assign count   = count_q;

endmodule

// File: tb/tb_topk_tracker.sv
// Bench for topk_tracker: unsigned and signed instances share one stimulus
// stream and are checked against a sorted-queue reference model.
module tb_topk_tracker;

  localparam int W = 8;
  localparam int K = 4;

  typedef logic [W-1:0] q8_t[$];

  logic         clk;
  logic         resetn;
  logic         clear;
  logic         din_valid;
  logic [W-1:0] din;
  logic         pop;
  logic [1:0]   rank_sel;

  logic [W-1:0] dout_u, dout_s, max_u, max_s;
  logic         dout_valid_u, dout_valid_s;
  logic [2:0]   count_u, count_s;

  int n_cmp;
  int n_bad;

  logic [W-1:0] exp_u_q[$];
  logic [W-1:0] exp_s_q[$];

  topk_tracker #(.DATA_WIDTH(W), .K(K), .SIGNED(0)) u_dut_u (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .din_valid  (din_valid),
    .din        (din),
    .pop        (pop),
    .rank_sel   (rank_sel),
    .dout       (dout_u),
    .dout_valid (dout_valid_u),
    .max_out    (max_u),
    .count      (count_u)
  );

  topk_tracker #(.DATA_WIDTH(W), .K(K), .SIGNED(1)) u_dut_s (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .din_valid  (din_valid),
    .din        (din),
    .pop        (pop),
    .rank_sel   (rank_sel),
    .dout       (dout_s),
    .dout_valid (dout_valid_s),
    .max_out    (max_s),
    .count      (count_s)
  );

  // Clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Ordering key for a sample under the given compare mode.
  function automatic int key(input logic [W-1:0] v, input bit sgn);
    if (sgn) return int'($signed(v));
    else     return int'(v);
  endfunction

  // Reference: optional pop of the front, then sorted insertion
  // (new sample goes below equals), then keep only the K largest.
  function automatic q8_t model_next(input q8_t q, input bit sgn, input bit c,
                                     input bit v, input logic [W-1:0] d, input bit p);
    q8_t r;
    logic [W-1:0] t;
    r = q;
    if (c) begin
      r.delete();
      return r;
    end
    if (p && (r.size() > 0)) void'(r.pop_front());
    if (v) begin
      r.push_back(d);
      for (int i = r.size() - 1; i > 0; i--) begin
        if (key(r[i], sgn) > key(r[i-1], sgn)) begin
          t = r[i]; r[i] = r[i-1]; r[i-1] = t;
        end else begin
          break;
        end
      end
      if (r.size() > K) void'(r.pop_back());
    end
    return r;
  endfunction

  function automatic logic [W-1:0] exp_at(input q8_t q, input int r);
    if (r < q.size()) return q[r];
    else              return '0;
  endfunction

  // Compare every rank plus count and max_out of both instances to the model.
  task automatic check_all();
    for (int r = 0; r < K; r++) begin
      rank_sel = 2'(r);
      #1;
      check($sformatf("dout_u[%0d]", r), 32'(dout_u), 32'(exp_at(exp_u_q, r)));
      check($sformatf("dvld_u[%0d]", r), 32'(dout_valid_u), 32'(r < exp_u_q.size()));
      check($sformatf("dout_s[%0d]", r), 32'(dout_s), 32'(exp_at(exp_s_q, r)));
      check($sformatf("dvld_s[%0d]", r), 32'(dout_valid_s), 32'(r < exp_s_q.size()));
    end
    check("count_u", 32'(count_u), 32'(exp_u_q.size()));
    check("count_s", 32'(count_s), 32'(exp_s_q.size()));
    check("max_u", 32'(max_u), 32'(exp_at(exp_u_q, 0)));
    check("max_s", 32'(max_s), 32'(exp_at(exp_s_q, 0)));
  endtask

  // Driver: apply one cycle of controls, advance the model at the edge, check.
  task automatic step(input bit c, input bit v, input logic [W-1:0] d, input bit p);
    clear = c; din_valid = v; din = d; pop = p;
    @(posedge clk);
    exp_u_q = model_next(exp_u_q, 1'b0, c, v, d, p);
    exp_s_q = model_next(exp_s_q, 1'b1, c, v, d, p);
    #1;
    clear = 1'b0; din_valid = 1'b0; pop = 1'b0;
    check_all();
  endtask

  task automatic push(input logic [W-1:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  // Hand-written anchor values independent of the model.
  task automatic expect_rank(input string tag, input int r, input bit sgn, input logic [W-1:0] val);
    rank_sel = 2'(r);
    #1;
    if (sgn) check(tag, 32'(dout_s), 32'(val));
    else     check(tag, 32'(dout_u), 32'(val));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    resetn = 1'b0; clear = 1'b0; din_valid = 1'b0; din = '0; pop = 1'b0; rank_sel = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #3;
    check("rst_count_u", 32'(count_u), 32'd0);
    check("rst_max_u", 32'(max_u), 32'd0);
    check("rst_dvld_u", 32'(dout_valid_u), 32'd0);
    check("rst_count_s", 32'(count_s), 32'd0);
    resetn = 1'b1;

    // Basic ordering.
    push(8'd5); push(8'd9); push(8'd3);
    expect_rank("tp1_r0", 0, 1'b0, 8'd9);
    expect_rank("tp1_r1", 1, 1'b0, 8'd5);
    expect_rank("tp1_r2", 2, 1'b0, 8'd3);
    expect_rank("tp1_r3", 3, 1'b0, 8'd0);
    check("tp1_r3_vld", 32'(dout_valid_u), 32'd0);
    check("tp1_count", 32'(count_u), 32'd3);

    // Overflow and tie-drop when full.
    step(1'b1, 1'b0, 8'd0, 1'b0);
    push(8'd10); push(8'd20); push(8'd30); push(8'd40); push(8'd50); push(8'd5);
    push(8'd20);
    expect_rank("ovf_r0", 0, 1'b0, 8'd50);
    expect_rank("ovf_r3", 3, 1'b0, 8'd20);
    check("ovf_count", 32'(count_u), 32'd4);

    // Pop, then pop+insert while full.
    step(1'b0, 1'b0, 8'd0, 1'b1);
    expect_rank("pop_r0", 0, 1'b0, 8'd40);
    check("pop_count", 32'(count_u), 32'd3);
    push(8'd50);
    step(1'b0, 1'b1, 8'd25, 1'b1);
    expect_rank("pi_r0", 0, 1'b0, 8'd40);
    expect_rank("pi_r2", 2, 1'b0, 8'd25);
    expect_rank("pi_r3", 3, 1'b0, 8'd20);
    check("pi_count", 32'(count_u), 32'd4);

    // Pop when empty.
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    check("pop_empty_count", 32'(count_u), 32'd0);

    // Duplicates.
    push(8'd7); push(8'd7); push(8'd7); push(8'd9);
    expect_rank("dup_r0", 0, 1'b0, 8'd9);
    expect_rank("dup_r3", 3, 1'b0, 8'd7);

    // Signed versus unsigned compare.
    step(1'b1, 1'b0, 8'd0, 1'b0);
    push(8'hFF); push(8'h01);
    expect_rank("sgn_u_r0", 0, 1'b0, 8'hFF);
    expect_rank("sgn_s_r0", 0, 1'b1, 8'h01);
    expect_rank("sgn_s_r1", 1, 1'b1, 8'hFF);

    // Clear beats a simultaneous insert.
    step(1'b1, 1'b1, 8'd99, 1'b0);
    check("clr_count", 32'(count_u), 32'd0);
    check("clr_max", 32'(max_u), 32'd0);

    // Asynchronous reset mid-stream, between edges.
    push(8'd11); push(8'd22);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #2;
    check("arst_count_u", 32'(count_u), 32'd0);
    check("arst_max_u", 32'(max_u), 32'd0);
    check("arst_count_s", 32'(count_s), 32'd0);
    check("arst_max_s", 32'(max_s), 32'd0);
    exp_u_q.delete();
    exp_s_q.delete();
    #2;
    resetn = 1'b1;
    push(8'd33);

    // Randomized traffic; small value range sometimes to force duplicates.
    for (int n = 0; n < 400; n++) begin
      bit c, v, p;
      logic [W-1:0] d;
      c = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 9) < 7);
      p = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 1) == 0) d = W'($urandom_range(0, 7));
      else                           d = W'($urandom_range(0, 255));
      step(c, v, d, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
